// File: rtl/arm_mem_subsys.sv
// Unified single-port memory subsystem: instruction fetch and data ports share one word RAM
// behind a round-robin arbiter, programmable wait states and a memory-mapped io_out register.
// Optional byte-lane data writes are enabled with the ARM_MEM_BYTE_WRITE_EN macro.
module arm_mem_subsys #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] IO_ADDR     = 32'hFC,
  parameter string       INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic [DATA_W-1:0]   io_out
);

  localparam int          BE_W      = DATA_W / 8;
  localparam int          OFF       = $clog2(BE_W);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * BE_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                gnt_data_q, gnt_data_d;
  logic                last_data_q, last_data_d;
  logic                err_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q, io_out_q;

  logic                we_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  logic                grant_data;
  logic                acc_data, acc_we;
  logic [31:0]         acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [BE_W-1:0]     acc_be;
  logic                do_access, hit_io, hit_ram;
  logic [AW-1:0]       ram_idx;
  logic [DATA_W-1:0]   rd_val, io_wr_val;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  // Round-robin: on contention the port that did not win last time is served.
  assign grant_data = d_req && (!i_req || !last_data_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_data_d  = gnt_data_q;
    last_data_d = last_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          gnt_data_d  = grant_data;
          last_data_d = grant_data;
          cnt_d       = 4'(WAIT_STATES);
          state_d     = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the grant edge, before anything is latched.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_data  = grant_data;
      acc_we    = grant_data && d_we;
      acc_addr  = grant_data ? d_addr : i_addr;
      acc_wdata = d_wdata;
      acc_be    = d_be;
    end else begin
      acc_data  = gnt_data_q;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign do_access = (state_d == S_RESP) && (state_q != S_RESP);
  assign hit_io    = (acc_addr == IO_ADDR);
  assign hit_ram   = (acc_addr < RAM_BYTES);
  assign ram_idx   = acc_addr[OFF +: AW];
  assign rd_val    = hit_io ? io_out_q : (hit_ram ? mem[ram_idx] : '0);

`ifdef ARM_MEM_BYTE_WRITE_EN
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  assign io_wr_val = lane_merge(io_out_q, acc_wdata, acc_be);
`else
  logic unused_be;
  assign io_wr_val = acc_wdata;
  assign unused_be = ^acc_be;
`endif

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      we_q    <= acc_we;
      addr_q  <= acc_addr;
      wdata_q <= acc_wdata;
      be_q    <= acc_be;
    end
  end

  // RAM is never cleared; an edge seen while reset is held low must not write it.
  always_ff @(posedge clk) begin
    if (do_access && reset && acc_we && !hit_io && hit_ram) begin
`ifdef ARM_MEM_BYTE_WRITE_EN
      for (int k = 0; k < BE_W; k++) begin
        if (acc_be[k]) mem[ram_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
      end
`else
      mem[ram_idx] <= acc_wdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      gnt_data_q  <= 1'b0;
      last_data_q <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      io_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_data_q  <= gnt_data_d;
      last_data_q <= last_data_d;
      if (do_access) begin
        err_q <= acc_data && !hit_io && !hit_ram;
        if (!acc_we) begin
          if (acc_data) d_rdata_q <= rd_val;
          else          i_rdata_q <= rd_val;
        end else if (hit_io) begin
          io_out_q <= io_wr_val;
        end
      end
    end
  end

  assign i_ready = (state_q == S_RESP) && !gnt_data_q;
  assign d_ready = (state_q == S_RESP) && gnt_data_q;
  assign d_err   = d_ready && err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign io_out  = io_out_q;

endmodule

// File: tb/tb_arm_mem_subsys.sv
// Directed bench for arm_mem_subsys: a 2-wait-state instance driven from a vector table plus
// hand-written reset/contention/fetch sequences, and a 0-wait-state instance for back-to-back reads.
module tb_arm_mem_subsys;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_be = 4'hF;
  logic        i_ready, d_ready, d_err;
  logic [31:0] i_rdata, d_rdata, io_out;

  logic        z_i_req = 0, z_d_req = 0, z_d_we = 0;
  logic [31:0] z_i_addr = 0, z_d_addr = 0, z_d_wdata = 0;
  logic [3:0]  z_d_be = 4'hF;
  logic        z_i_ready, z_d_ready, z_d_err;
  logic [31:0] z_i_rdata, z_d_rdata, z_io_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arm_mem_subsys #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(2), .IO_ADDR(32'hFC)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err), .io_out(io_out)
  );

  arm_mem_subsys #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(0), .IO_ADDR(32'hFC)) u_z (
    .clk(clk), .reset(reset),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ready(z_i_ready), .i_rdata(z_i_rdata),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata), .d_be(z_d_be),
    .d_ready(z_d_ready), .d_rdata(z_d_rdata), .d_err(z_d_err), .io_out(z_io_out)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_io;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic d_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat, output logic saw_i);
    logic done;
    d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
    lat = 0; rdata = '0; err = 1'b0; done = 1'b0; saw_i = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (i_ready) saw_i = 1'b1;
      if (d_ready) begin
        rdata = d_rdata; err = d_err; done = 1'b1;
      end
    end
    d_req = 1'b0;
    if (done) begin
      @(posedge clk); @(negedge clk);
      chk("d_ready_pulse_width", 32'(d_ready), 32'd0);
    end
  endtask

  task automatic i_xact(input logic [31:0] addr, output logic [31:0] rdata, output int lat,
                        output logic saw_d);
    logic done;
    i_addr = addr; i_req = 1'b1;
    lat = 0; rdata = '0; done = 1'b0; saw_d = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (d_ready || d_err) saw_d = 1'b1;
      if (i_ready) begin
        rdata = i_rdata; done = 1'b1;
      end
    end
    i_req = 1'b0;
    if (done) begin
      @(posedge clk); @(negedge clk);
      chk("i_ready_pulse_width", 32'(i_ready), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd, exp14;
    logic        er, saw;
    int          lat;

`ifdef ARM_MEM_BYTE_WRITE_EN
    exp14 = 32'h11BB33DD;
`else
    exp14 = 32'hAABBCCDD;
`endif

    tbl[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 32'h010, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 32'h014, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 32'h014, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0, 32'h00};
    tbl[4]  = '{1'b0, 32'h014, 32'h00000000, 4'hF, exp14,        1'b0, 32'h00};
    tbl[5]  = '{1'b1, 32'h0FC, 32'h0000005A, 4'hF, exp14,        1'b0, 32'h5A};
    tbl[6]  = '{1'b0, 32'h0FC, 32'h00000000, 4'hF, 32'h0000005A, 1'b0, 32'h5A};
    tbl[7]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0000005A, 1'b0, 32'h5A};
    tbl[8]  = '{1'b0, 32'h3FC, 32'h00000000, 4'hF, 32'hCAFEF00D, 1'b0, 32'h5A};
    tbl[9]  = '{1'b1, 32'h400, 32'h12345678, 4'hF, 32'hCAFEF00D, 1'b1, 32'h5A};
    tbl[10] = '{1'b0, 32'h400, 32'h00000000, 4'hF, 32'h00000000, 1'b1, 32'h5A};
    tbl[11] = '{1'b1, 32'h013, 32'h01020304, 4'hF, 32'h00000000, 1'b0, 32'h5A};
    tbl[12] = '{1'b0, 32'h010, 32'h00000000, 4'hF, 32'h01020304, 1'b0, 32'h5A};
    tbl[13] = '{1'b0, 32'h3FC, 32'h00000000, 4'hF, 32'hCAFEF00D, 1'b0, 32'h5A};

    // reset state of both instances
    repeat (3) @(negedge clk);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_d_err",   32'(d_err),   32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_io_out",  io_out,  32'd0);
    chk("rst_z_ready", 32'({z_i_ready, z_d_ready, z_d_err}), 32'd0);
    chk("rst_z_data",  z_i_rdata | z_d_rdata | z_io_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      d_xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat, saw);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_io_out", i), io_out, tbl[i].exp_io);
      chk($sformatf("vec%0d_no_i_ready", i), 32'(saw), 32'd0);
    end

    i_xact(32'h010, rd, lat, saw);
    chk("fetch10_latency", 32'(lat), 32'd3);
    chk("fetch10_rdata", rd, 32'h01020304);
    chk("fetch10_no_d_ready", 32'(saw), 32'd0);
    i_xact(32'h400, rd, lat, saw);
    chk("fetch_oor_rdata", rd, 32'd0);
    chk("fetch_oor_no_d_err", 32'(saw), 32'd0);
    i_xact(32'h0FC, rd, lat, saw);
    chk("fetch_io_rdata", rd, 32'h5A);
    chk("d_rdata_held_over_fetch", d_rdata, 32'hCAFEF00D);

    // reset while a write to 0x10 sits in WAIT
    d_we = 1'b1; d_addr = 32'h010; d_wdata = 32'h99999999; d_be = 4'hF; d_req = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("midwait_no_ready", 32'(d_ready), 32'd0);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("midrst_ready", 32'({i_ready, d_ready, d_err}), 32'd0);
    chk("midrst_i_rdata", i_rdata, 32'd0);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    chk("midrst_io_out", io_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // contention from a fresh reset: D first, then alternate, period 4
    d_we = 1'b0; d_addr = 32'h010; i_addr = 32'h3FC; d_req = 1'b1; i_req = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("cont_d_ready_c%0d", n), 32'(d_ready), 32'((n == 3) || (n == 11)));
      chk($sformatf("cont_i_ready_c%0d", n), 32'(i_ready), 32'((n == 7) || (n == 15)));
    end
    d_req = 1'b0; i_req = 1'b0;
    chk("cont_d_rdata_mem4_kept", d_rdata, 32'h01020304);
    chk("cont_i_rdata", i_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // zero wait states: write then back-to-back reads of the same word
    z_d_we = 1'b1; z_d_addr = 32'h020; z_d_wdata = 32'h13579BDF; z_d_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("z_write_ready", 32'(z_d_ready), 32'd1);
    chk("z_write_rdata_kept", z_d_rdata, 32'd0);
    z_d_we = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("z_rd_ready_c%0d", n), 32'(z_d_ready), 32'(n % 2 == 0));
      if (n == 2) chk("z_rd_new_value", z_d_rdata, 32'h13579BDF);
    end
    z_d_req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
